cia_eclk_sched: RTL and testbench

Sequences 6800-style synchronous peripheral cycles to the two CIAs, aligned to the 10-phase one-hot E-clock shifter produced by the clock generator. Arbitrates between a CPU port and an optional host (APF bridge) port. Drives the CIA select, address, data and VMA signals, and returns read data and a one-cycle acknowledge. Sits between the CPU bus decoder and the CIA pair, entirely in the clk_28 domain.

---
 rtl/cia_eclk_sched.sv | 155 +++++++++++++++
 tb/tb_cia_eclk_sched.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/cia_eclk_sched.sv
// cia_eclk_sched: sequences 6800-style E-clock peripheral cycles to the CIA pair.
// Ports:
//   clk_28_i, reset_n_i            28 MHz clock, synchronous active-low reset
//   eclk_i[9:0]                    one-hot E phase, advances every 4 clk_28
//   cpu_req_i/rw/sel/addr/wdata    CPU request port (req held until ack)
//   cpu_ack_o, cpu_rdata_o         one-cycle completion pulse, read data
//   host_* (CIA_SCHED_HOST_EN)     optional host port, same meanings as CPU
//   cia_e/vma/sel/rw/addr/wdata_o  registered 6800 bus to the CIAs
//   cia_rdata_i                    muxed CIA read data
//   busy_o                         high whenever the sequencer is not IDLE
// Build option: define CIA_SCHED_HOST_EN to add the host port and
// alternating-priority arbitration.
module cia_eclk_sched (
    input  logic       clk_28_i,
    input  logic       reset_n_i,
    input  logic [9:0] eclk_i,
    input  logic       cpu_req_i,
    input  logic       cpu_rw_i,
    input  logic [1:0] cpu_sel_i,
    input  logic [3:0] cpu_addr_i,
    input  logic [7:0] cpu_wdata_i,
    output logic       cpu_ack_o,
    output logic [7:0] cpu_rdata_o,
`ifdef CIA_SCHED_HOST_EN
    input  logic       host_req_i,
    input  logic       host_rw_i,
    input  logic [1:0] host_sel_i,
    input  logic [3:0] host_addr_i,
    input  logic [7:0] host_wdata_i,
    output logic       host_ack_o,
    output logic [7:0] host_rdata_o,
`endif
    output logic       cia_e_o,
    output logic       cia_vma_o,
    output logic [1:0] cia_sel_o,
    output logic       cia_rw_o,
    output logic [3:0] cia_addr_o,
    output logic [7:0] cia_wdata_o,
    input  logic [7:0] cia_rdata_i,
    output logic       busy_o
);
    typedef enum logic [2:0] {IDLE, SYNC, VMA, EHIGH, DONE} state_t;
    state_t     state_q, state_d;
    logic       onehot, req_any, done;
    logic       w_rw, rw_q, host_gnt;
    logic [1:0] w_sel, sel_q;
    logic [3:0] w_addr, addr_q;
    logic [7:0] w_wdata, wdata_q;
    logic       cpu_ack_q, cia_e_q, cia_vma_q, cia_rw_q, busy_q;
    logic [1:0] cia_sel_q;
    logic [3:0] cia_addr_q;
    logic [7:0] cpu_rdata_q, cia_wdata_q;
    // A glitched or all-zero shifter must never be mistaken for a phase.
    assign onehot = (eclk_i != '0) && ((eclk_i & (eclk_i - 10'd1)) == '0);
`ifdef CIA_SCHED_HOST_EN
    logic       grant_host, gnt_host_q, last_host_q, host_ack_q;
    logic [7:0] host_rdata_q;
    // last_host_q = 1 means the host was served last, so the CPU wins a tie.
    assign grant_host = host_req_i && (!cpu_req_i || !last_host_q);
    assign req_any    = cpu_req_i || host_req_i;
    assign host_gnt   = gnt_host_q;
    assign w_rw       = grant_host ? host_rw_i    : cpu_rw_i;
    assign w_sel      = grant_host ? host_sel_i   : cpu_sel_i;
    assign w_addr     = grant_host ? host_addr_i  : cpu_addr_i;
    assign w_wdata    = grant_host ? host_wdata_i : cpu_wdata_i;
    assign host_ack_o   = host_ack_q;
    assign host_rdata_o = host_rdata_q;
`else
    assign req_any  = cpu_req_i;
    assign host_gnt = 1'b0;
    assign w_rw     = cpu_rw_i;
    assign w_sel    = cpu_sel_i;
    assign w_addr   = cpu_addr_i;
    assign w_wdata  = cpu_wdata_i;
`endif
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = req_any ? SYNC : IDLE;
            SYNC:    state_d = (eclk_i == 10'b0000000100) ? VMA : SYNC;
            VMA:     state_d = (onehot && eclk_i[6]) ? EHIGH : VMA;
            EHIGH:   state_d = (onehot && eclk_i[0]) ? DONE : EHIGH;
            default: state_d = IDLE;
        endcase
    end
    assign done = (state_q == EHIGH) && (state_d == DONE);
    always_ff @(posedge clk_28_i) begin
        if (!reset_n_i) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            cia_e_q     <= 1'b0;
            cia_vma_q   <= 1'b0;
            cia_sel_q   <= 2'b00;
            cia_rw_q    <= 1'b1;
            cia_addr_q  <= 4'h0;
            cia_wdata_q <= 8'h00;
            cpu_ack_q   <= 1'b0;
            cpu_rdata_q <= 8'h00;
            rw_q        <= 1'b1;
            sel_q       <= 2'b00;
            addr_q      <= 4'h0;
            wdata_q     <= 8'h00;
`ifdef CIA_SCHED_HOST_EN
            gnt_host_q   <= 1'b0;
            last_host_q  <= 1'b1;
            host_ack_q   <= 1'b0;
            host_rdata_q <= 8'h00;
`endif
        end else begin
            state_q   <= state_d;
            busy_q    <= state_d != IDLE;
            cia_e_q   <= |eclk_i[9:6];
            cpu_ack_q <= done && !host_gnt;
            if (state_q == IDLE && req_any) begin
                rw_q    <= w_rw;
                sel_q   <= w_sel;
                addr_q  <= w_addr;
                wdata_q <= w_wdata;
`ifdef CIA_SCHED_HOST_EN
                gnt_host_q <= grant_host;
`endif
            end
            if (state_q == SYNC && state_d == VMA) begin
                cia_vma_q   <= 1'b1;
                cia_rw_q    <= rw_q;
                cia_addr_q  <= addr_q;
                cia_wdata_q <= wdata_q;
            end
            if (state_q == VMA && state_d == EHIGH)
                cia_sel_q <= sel_q;
            if (done) begin
                cia_vma_q <= 1'b0;
                cia_sel_q <= 2'b00;
                if (rw_q && !host_gnt)
                    cpu_rdata_q <= cia_rdata_i;
            end
`ifdef CIA_SCHED_HOST_EN
            host_ack_q <= done && gnt_host_q;
            if (done && rw_q && gnt_host_q)
                host_rdata_q <= cia_rdata_i;
            if (state_q == DONE)
                last_host_q <= gnt_host_q;
`endif
        end
    end
    assign cpu_ack_o   = cpu_ack_q;
    assign cpu_rdata_o = cpu_rdata_q;
    assign cia_e_o     = cia_e_q;
    assign cia_vma_o   = cia_vma_q;
    assign cia_sel_o   = cia_sel_q;
    assign cia_rw_o    = cia_rw_q;
    assign cia_addr_o  = cia_addr_q;
    assign cia_wdata_o = cia_wdata_q;
    assign busy_o      = busy_q;
endmodule

// File: tb/tb_cia_eclk_sched.sv
// tb_cia_eclk_sched: directed self-checking bench for cia_eclk_sched.
module tb_cia_eclk_sched;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [9:0] eclk_r = 10'b1;
    logic [1:0] cnt = 2'd0;
    logic       eclk_zero = 1'b0;
    logic [9:0] eclk, eclk_smp;
    logic       cpu_req = 1'b0, cpu_rw = 1'b1;
    logic [1:0] cpu_sel = 2'b00;
    logic [3:0] cpu_addr = 4'h0;
    logic [7:0] cpu_wdata = 8'h00;
    logic       cpu_ack;
    logic [7:0] cpu_rdata;
    logic       cia_e, cia_vma, cia_rw, busy;
    logic [1:0] cia_sel;
    logic [3:0] cia_addr;
    logic [7:0] cia_wdata, cia_rdata = 8'h00;
`ifdef CIA_SCHED_HOST_EN
    logic       host_req = 1'b0, host_rw = 1'b1;
    logic [1:0] host_sel = 2'b00;
    logic [3:0] host_addr = 4'h0;
    logic [7:0] host_wdata = 8'h00;
    logic       host_ack;
    logic [7:0] host_rdata;
`endif
    int errors = 0;
    int checks = 0;
    cia_eclk_sched dut (
        .clk_28_i(clk), .reset_n_i(reset_n), .eclk_i(eclk),
        .cpu_req_i(cpu_req), .cpu_rw_i(cpu_rw), .cpu_sel_i(cpu_sel),
        .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
        .cpu_ack_o(cpu_ack), .cpu_rdata_o(cpu_rdata),
`ifdef CIA_SCHED_HOST_EN
        .host_req_i(host_req), .host_rw_i(host_rw), .host_sel_i(host_sel),
        .host_addr_i(host_addr), .host_wdata_i(host_wdata),
        .host_ack_o(host_ack), .host_rdata_o(host_rdata),
`endif
        .cia_e_o(cia_e), .cia_vma_o(cia_vma), .cia_sel_o(cia_sel),
        .cia_rw_o(cia_rw), .cia_addr_o(cia_addr), .cia_wdata_o(cia_wdata),
        .cia_rdata_i(cia_rdata), .busy_o(busy)
    );
    always #5 clk = ~clk;
    // Free-running E shifter: one phase per 4 clocks; eclk_smp is what the DUT saw at the last edge.
    assign eclk = eclk_zero ? 10'b0 : eclk_r;
    always @(posedge clk) begin
        cnt      <= cnt + 2'd1;
        eclk_r   <= (cnt == 2'd3) ? {eclk_r[8:0], eclk_r[9]} : eclk_r;
        eclk_smp <= eclk;
    end
    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic start_req(input logic rw, input logic [1:0] sel, input logic [3:0] addr,
                             input logic [7:0] wd);
        cpu_rw = rw; cpu_sel = sel; cpu_addr = addr; cpu_wdata = wd; cpu_req = 1'b1;
    endtask
    task automatic finish_cycle(input string tg, input logic rw, input logic [1:0] sel,
                                input logic [3:0] addr, input logic [7:0] wd,
                                input logic [7:0] exp_rd, output int lat);
        bit seen_vma = 0, seen_sel = 0, hold_bad = 0, got = 0;
        int n = 0;
        while (!got && n < 200) begin
            @(negedge clk);
            n++;
            if (cia_vma && !seen_vma) begin
                seen_vma = 1;
                chk({tg, "_vma_rise"}, {20'h0, eclk_smp, cia_sel}, {20'h0, 10'h004, 2'b00});
            end
            if (cia_sel != 2'b00 && !seen_sel) begin
                seen_sel = 1;
                chk({tg, "_sel_rise"}, {eclk_smp[6], cia_vma, cia_sel}, {2'b11, sel});
            end
            if (cia_vma && (cia_rw !== rw || cia_addr !== addr || (!rw && cia_wdata !== wd)))
                hold_bad = 1;
            if (cpu_ack) got = 1;
        end
        lat = n;
        chk({tg, "_ack_seen"}, got, 1);
        chk({tg, "_bus_hold"}, hold_bad, 0);
        chk({tg, "_ack_bus"}, {eclk_smp[0], cia_vma, cia_sel}, 4'b1000);
        chk({tg, "_rdata"}, cpu_rdata, exp_rd);
        cpu_req = 1'b0;
        @(negedge clk);
        chk({tg, "_ack_pulse"}, {cpu_ack, busy}, 2'b00);
    endtask
    initial begin
        int lat, n, acks;
        bit bad;
        repeat (3) @(negedge clk);
        chk("rst_ack", cpu_ack, 0);
        chk("rst_rdata", cpu_rdata, 0);
        chk("rst_vma_sel", {cia_vma, cia_sel}, 0);
        chk("rst_rw", cia_rw, 1);
        chk("rst_addr_wdata", {cia_addr, cia_wdata}, 0);
        chk("rst_e_busy", {cia_e, busy}, 0);
        reset_n = 1'b1;
        // cia_e follows eclk[9:6] one clock late.
        n = 0;
        do begin @(negedge clk); n++; end while (!(eclk[6] && cnt == 2'd0) && n < 60);
        chk("e_rise_lag0", cia_e, 0);
        @(negedge clk);
        chk("e_rise_lag1", cia_e, 1);
        n = 0;
        do begin @(negedge clk); n++; end while (!(eclk[0] && cnt == 2'd0) && n < 60);
        chk("e_fall_lag0", cia_e, 1);
        @(negedge clk);
        chk("e_fall_lag1", cia_e, 0);
        cia_rdata = 8'h5A;
        start_req(1'b1, 2'b01, 4'hD, 8'h00);
        finish_cycle("rd", 1'b1, 2'b01, 4'hD, 8'h00, 8'h5A, lat);
        cia_rdata = 8'hEE;
        start_req(1'b0, 2'b10, 4'h3, 8'hC3);
        finish_cycle("wr", 1'b0, 2'b10, 4'h3, 8'hC3, 8'h5A, lat);
        // Request at the first clock of phase 3: SYNC waits until phase 2 is sampled
        // 37 edges later, VMA->EHIGH takes 16 more, EHIGH->DONE 16 more: ack 69 clocks out.
        n = 0;
        do begin @(negedge clk); n++; end while (!(eclk == 10'h008 && cnt == 2'd0) && n < 60);
        cia_rdata = 8'h3C;
        start_req(1'b1, 2'b01, 4'h7, 8'h00);
        finish_cycle("late", 1'b1, 2'b01, 4'h7, 8'h00, 8'h3C, lat);
        chk("late_latency", lat, 69);
        start_req(1'b1, 2'b01, 4'h2, 8'h00);
        n = 0;
        do begin @(negedge clk); n++; end while (cia_sel == 2'b00 && n < 100);
        chk("rst_mid_ehigh_reached", cia_sel, 2'b01);
        reset_n = 1'b0;
        cpu_req = 1'b0;
        @(negedge clk);
        chk("rst_mid_outputs", {cia_vma, cia_sel, busy, cpu_ack}, 0);
        reset_n = 1'b1;
        acks = 0;
        repeat (100) begin @(negedge clk); if (cpu_ack) acks++; end
        chk("rst_mid_no_ack", acks, 0);
        chk("rst_mid_rdata", cpu_rdata, 0);
        cia_rdata = 8'hA5;
        start_req(1'b1, 2'b11, 4'h1, 8'h00);
        finish_cycle("post_rst", 1'b1, 2'b11, 4'h1, 8'h00, 8'hA5, lat);
        cia_rdata = 8'h96;
        start_req(1'b1, 2'b10, 4'hE, 8'h00);
        eclk_zero = 1'b1;
        bad = 0;
        repeat (60) begin @(negedge clk); if (!busy || cia_vma || cpu_ack) bad = 1; end
        chk("ezero_hold_sync", bad, 0);
        eclk_zero = 1'b0;
        finish_cycle("ezero", 1'b1, 2'b10, 4'hE, 8'h00, 8'h96, lat);
`ifdef CIA_SCHED_HOST_EN
        begin
            logic [2:0] order = 3'b000;
            bit dual = 0;
            int k = 0;
            reset_n = 1'b0;
            @(negedge clk);
            reset_n = 1'b1;
            cia_rdata = 8'h77;
            start_req(1'b1, 2'b01, 4'h4, 8'h00);
            host_rw = 1'b1; host_sel = 2'b10; host_addr = 4'h5; host_req = 1'b1;
            n = 0;
            while (k < 3 && n < 300) begin
                @(negedge clk);
                n++;
                if (cpu_ack && host_ack) dual = 1;
                if (cpu_ack || host_ack) begin order[k] = host_ack; k++; end
                if (k == 3) begin cpu_req = 1'b0; host_req = 1'b0; end
            end
            chk("arb_ack_count", k, 3);
            chk("arb_order", order, 3'b010);
            chk("arb_no_dual", dual, 0);
            chk("arb_rdata", {cpu_rdata, host_rdata}, 16'h7777);
            @(negedge clk);
            chk("arb_ack_pulse", {cpu_ack, host_ack}, 2'b00);
        end
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
